// File: rtl/hazard_stall_unit_pkg.sv
// rtl/hazard_stall_unit_pkg.sv - opcode/RegDst constants, FSM state type and source-match helpers
package hazard_stall_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LW    = 6'h23;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  typedef enum logic {RUN, STALL} stallState_t;

  // rt is a genuine source only for R-type, beq/bne and sw; for other
  // I-types it is the destination and must not trigger a hazard.
  function automatic logic readsRt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
           (opcode == OP_BNE)   || (opcode == OP_SW);
  endfunction

  // $0 is hardwired, so a write to it never creates a dependency.
  function automatic logic srcMatch(input logic [4:0] dest, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic rtUsed);
    return (dest != 5'd0) && ((dest == rs) || (rtUsed && (dest == rt)));
  endfunction

endpackage

// File: rtl/hazard_dest_decode.sv
// rtl/hazard_dest_decode.sv - register-file write address of an in-flight instruction
// ir       : instruction word
// regDst   : destination select (00 rt, 01 rd, other $31)
// destAddr : 5-bit write address
module hazard_dest_decode
  import hazard_stall_unit_pkg::*;
(
  input  logic [31:0] ir,
  input  logic [1:0]  regDst,
  output logic [4:0]  destAddr
);

  logic unusedIrBits;
  assign unusedIrBits = ^{ir[31:21], ir[10:0]};

  always_comb begin
    destAddr = 5'd31;
    case (regDst)
      REGDST_RT: destAddr = ir[20:16];
      REGDST_RD: destAddr = ir[15:11];
      default:   destAddr = 5'd31;
    endcase
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - RAW stall/flush controller for the 5-stage pipeline
// clk, reset                : clock, synchronous active-high reset
// IR_*_out, *_ID_EX/EX_MEM  : instructions and control bits held in IF/ID, ID/EX, EX/MEM
// Branch/JumpReg/Jump_ID    : ID-stage control-flow info, BranchTaken_ID condition result
// DMem_Busy                 : data memory stall, freezes everything
// PC_Write, IF_ID_Write     : front-end enables
// IF_ID_Flush, ID_EX_Flush  : bubble insertion controls
// Pipe_Hold                 : hold back-end pipeline registers
// Stall_Count, Flush_Count  : performance counters
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IR_IF_ID_out,
  input  logic [31:0]      IR_ID_EX_out,
  input  logic             RegWrite_ID_EX_out,
  input  logic             MemRead_ID_EX_out,
  input  logic [1:0]       RegDst_ID_EX_out,
  input  logic [31:0]      IR_EX_MEM_out,
  input  logic             MemRead_EX_MEM_out,
  input  logic [1:0]       RegDst_EX_MEM_out,
  input  logic             Branch_ID,
  input  logic             JumpReg_ID,
  input  logic             BranchTaken_ID,
  input  logic             Jump_ID,
  input  logic             DMem_Busy,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             Pipe_Hold,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  localparam int CW = $clog2(MAX_STALL + 1);

  stallState_t   state;
  logic [CW-1:0] cnt;

  logic [4:0]    exDest;
  logic [4:0]    memDest;
  logic [4:0]    idRs;
  logic [4:0]    idRt;
  logic          rtUsed;
  logic          exMatch;
  logic          memMatch;
  logic          readsInId;
  logic [1:0]    needRaw;
  logic [CW-1:0] need;
  logic          stalling;
  logic          unusedIfIdBits;

  hazard_dest_decode exDecode (
    .ir       (IR_ID_EX_out),
    .regDst   (RegDst_ID_EX_out),
    .destAddr (exDest)
  );

  hazard_dest_decode memDecode (
    .ir       (IR_EX_MEM_out),
    .regDst   (RegDst_EX_MEM_out),
    .destAddr (memDest)
  );

  assign idRs           = IR_IF_ID_out[25:21];
  assign idRt           = IR_IF_ID_out[20:16];
  assign rtUsed         = readsRt(IR_IF_ID_out[31:26]);
  assign unusedIfIdBits = ^IR_IF_ID_out[15:0];
  assign exMatch        = srcMatch(exDest, idRs, idRt, rtUsed);
  assign memMatch       = srcMatch(memDest, idRs, idRt, rtUsed);
  // Branches and jr/jalr consume operands in ID, ahead of the bypass network.
  assign readsInId      = Branch_ID | JumpReg_ID;

  always_comb begin
    needRaw = 2'd0;
    if (readsInId && MemRead_ID_EX_out && exMatch) begin
      needRaw = 2'd2;
    end else if ((MemRead_ID_EX_out && exMatch) ||
                 (readsInId && RegWrite_ID_EX_out && exMatch) ||
                 (readsInId && MemRead_EX_MEM_out && memMatch)) begin
      needRaw = 2'd1;
    end
  end

  assign need     = (32'(needRaw) > MAX_STALL) ? CW'(MAX_STALL) : CW'(needRaw);
  assign stalling = (state == STALL) || (need != '0);

  // Reset outranks the memory freeze, which outranks stalls, which outrank flushes.
  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    Pipe_Hold   = 1'b0;
    if (reset) begin
      PC_Write    = 1'b1;
    end else if (DMem_Busy) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      Pipe_Hold   = 1'b1;
    end else if (stalling) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end else begin
      IF_ID_Flush = (BranchTaken_ID & Branch_ID) | Jump_ID;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      cnt         <= '0;
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else if (!DMem_Busy) begin
      Stall_Count <= Stall_Count + CNT_W'(ID_EX_Flush);
      Flush_Count <= Flush_Count + CNT_W'(IF_ID_Flush);
      case (state)
        RUN: begin
          // The RUN cycle itself is the first stall cycle; STALL covers the rest.
          if (32'(need) >= 2) begin
            state <= STALL;
            cnt   <= need - CW'(1);
          end
        end
        STALL: begin
          cnt <= cnt - CW'(1);
          if (cnt <= CW'(1)) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_IF_ID_out, IR_ID_EX_out, IR_EX_MEM_out;
  logic        RegWrite_ID_EX_out, MemRead_ID_EX_out, MemRead_EX_MEM_out;
  logic [1:0]  RegDst_ID_EX_out, RegDst_EX_MEM_out;
  logic        Branch_ID, JumpReg_ID, BranchTaken_ID, Jump_ID, DMem_Busy;
  logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold;
  logic [31:0] Stall_Count, Flush_Count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [4:0] ctl;
    int         sc;
    int         fc;
  } expect_t;

  expect_t expQ[$];
  expect_t cur;

  // ctl = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold}
  localparam logic [4:0] NORM  = 5'b11000;
  localparam logic [4:0] STL   = 5'b00010;
  localparam logic [4:0] FLUSH = 5'b11100;
  localparam logic [4:0] BUSY  = 5'b00001;

  hazard_stall_unit #(.CNT_W(32), .MAX_STALL(2)) dut (
    .clk                (clk),
    .reset              (reset),
    .IR_IF_ID_out       (IR_IF_ID_out),
    .IR_ID_EX_out       (IR_ID_EX_out),
    .RegWrite_ID_EX_out (RegWrite_ID_EX_out),
    .MemRead_ID_EX_out  (MemRead_ID_EX_out),
    .RegDst_ID_EX_out   (RegDst_ID_EX_out),
    .IR_EX_MEM_out      (IR_EX_MEM_out),
    .MemRead_EX_MEM_out (MemRead_EX_MEM_out),
    .RegDst_EX_MEM_out  (RegDst_EX_MEM_out),
    .Branch_ID          (Branch_ID),
    .JumpReg_ID         (JumpReg_ID),
    .BranchTaken_ID     (BranchTaken_ID),
    .Jump_ID            (Jump_ID),
    .DMem_Busy          (DMem_Busy),
    .PC_Write           (PC_Write),
    .IF_ID_Write        (IF_ID_Write),
    .IF_ID_Flush        (IF_ID_Flush),
    .ID_EX_Flush        (ID_EX_Flush),
    .Pipe_Hold          (Pipe_Hold),
    .Stall_Count        (Stall_Count),
    .Flush_Count        (Flush_Count)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      cur = expQ.pop_front();
      checkVal({cur.tag, "/ctl"}, 32'({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold}), 32'(cur.ctl));
      checkVal({cur.tag, "/stallCnt"}, Stall_Count, cur.sc);
      checkVal({cur.tag, "/flushCnt"}, Flush_Count, cur.fc);
    end
  end

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  // Called just after a rising edge: push expectation, then let the edge apply.
  task automatic step(input string tag, input logic [4:0] ctl, input int sc, input int fc);
    expect_t e;
    e.tag = tag; e.ctl = ctl; e.sc = sc; e.fc = fc;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IR_IF_ID_out = 32'd0; IR_ID_EX_out = 32'd0; IR_EX_MEM_out = 32'd0;
    RegWrite_ID_EX_out = 1'b0; MemRead_ID_EX_out = 1'b0; MemRead_EX_MEM_out = 1'b0;
    RegDst_ID_EX_out = 2'b00; RegDst_EX_MEM_out = 2'b00;
    Branch_ID = 1'b0; JumpReg_ID = 1'b0; BranchTaken_ID = 1'b0; Jump_ID = 1'b0;
    DMem_Busy = 1'b0;
  endtask

  task automatic exClear();
    IR_ID_EX_out = 32'd0; RegWrite_ID_EX_out = 1'b0; MemRead_ID_EX_out = 1'b0;
    RegDst_ID_EX_out = 2'b00;
  endtask

  task automatic exLoad(input logic [4:0] rt);
    IR_ID_EX_out = iType(6'h23, 5'd9, rt, 16'd0);
    RegWrite_ID_EX_out = 1'b1; MemRead_ID_EX_out = 1'b1; RegDst_ID_EX_out = 2'b00;
  endtask

  task automatic exAlu(input logic [4:0] rd);
    IR_ID_EX_out = rType(5'd9, 5'd10, rd, 6'h20);
    RegWrite_ID_EX_out = 1'b1; MemRead_ID_EX_out = 1'b0; RegDst_ID_EX_out = 2'b01;
  endtask

  task automatic idBranch(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic taken);
    IR_IF_ID_out = iType(op, rs, rt, 16'd4);
    Branch_ID = 1'b1; BranchTaken_ID = taken; JumpReg_ID = 1'b0; Jump_ID = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    step("reset", NORM, 0, 0);
    reset = 1'b0;

    // load-use with R-type consumer
    exLoad(5'd8); IR_IF_ID_out = rType(5'd8, 5'd11, 5'd10, 6'h20);
    step("lu_stall", STL, 0, 0);
    exClear();
    step("lu_after", NORM, 1, 0);

    // load then branch: two stall cycles, then taken branch flushes
    exLoad(5'd8); idBranch(6'h04, 5'd8, 5'd0, 1'b0);
    step("lb_stall1", STL, 1, 0);
    exClear(); IR_EX_MEM_out = iType(6'h23, 5'd9, 5'd8, 16'd0); MemRead_EX_MEM_out = 1'b1;
    step("lb_stall2", STL, 2, 0);
    IR_EX_MEM_out = 32'd0; MemRead_EX_MEM_out = 1'b0; BranchTaken_ID = 1'b1;
    step("lb_taken", FLUSH, 3, 0);
    idle();
    step("lb_idle", NORM, 3, 1);

    // ALU result into branch: one stall; $0 destination never stalls
    exAlu(5'd8); idBranch(6'h05, 5'd8, 5'd9, 1'b0);
    step("ab_stall", STL, 3, 1);
    exClear();
    step("ab_after", NORM, 4, 1);
    exAlu(5'd0); idBranch(6'h05, 5'd0, 5'd9, 1'b0);
    step("ab_zero", NORM, 4, 1);
    idle(); exAlu(5'd8); IR_IF_ID_out = rType(5'd8, 5'd11, 5'd10, 6'h20);
    step("alu_bypass", NORM, 4, 1);

    // source decoding: sw reads rt, addi via rs, ori's rt is not a source
    idle(); exLoad(5'd8); IR_IF_ID_out = iType(6'h2B, 5'd2, 5'd8, 16'd4);
    step("sw_rt", STL, 4, 1);
    exClear();
    step("sw_after", NORM, 5, 1);
    exLoad(5'd8); IR_IF_ID_out = iType(6'h08, 5'd8, 5'd8, 16'd1);
    step("addi_rs", STL, 5, 1);
    exClear();
    step("addi_after", NORM, 6, 1);
    exLoad(5'd3); IR_IF_ID_out = iType(6'h0D, 5'd4, 5'd3, 16'd1);
    step("ori_none", NORM, 6, 1);

    // jal ($31 via RegDst=10) feeding jr: stall, then jump flush
    idle();
    IR_ID_EX_out = {6'h03, 26'd100}; RegWrite_ID_EX_out = 1'b1; RegDst_ID_EX_out = 2'b10;
    IR_IF_ID_out = rType(5'd31, 5'd0, 5'd0, 6'h08); JumpReg_ID = 1'b1; Jump_ID = 1'b1;
    step("jr_stall", STL, 6, 1);
    exClear();
    step("jr_flush", FLUSH, 7, 1);
    idle();
    step("jr_idle", NORM, 7, 2);

    // memory busy while in STALL freezes state and counters
    exLoad(5'd8); idBranch(6'h04, 5'd8, 5'd0, 1'b0);
    step("mb_stall1", STL, 7, 2);
    exClear(); DMem_Busy = 1'b1;
    step("mb_busy1", BUSY, 8, 2);
    step("mb_busy2", BUSY, 8, 2);
    step("mb_busy3", BUSY, 8, 2);
    DMem_Busy = 1'b0;
    step("mb_stall2", STL, 8, 2);
    step("mb_run", NORM, 9, 2);

    // busy in RUN masks a pending load-use stall
    idle(); exLoad(5'd8); IR_IF_ID_out = rType(5'd8, 5'd11, 5'd10, 6'h20); DMem_Busy = 1'b1;
    step("mr_busy", BUSY, 9, 2);
    DMem_Busy = 1'b0;
    step("mr_stall", STL, 9, 2);
    exClear();
    step("mr_after", NORM, 10, 2);

    // reset while in STALL abandons the stall
    idle(); exLoad(5'd8); idBranch(6'h04, 5'd8, 5'd0, 1'b0);
    step("rs_stall1", STL, 10, 2);
    reset = 1'b1;
    step("rs_reset", NORM, 11, 2);
    reset = 1'b0; exClear(); BranchTaken_ID = 1'b1;
    step("rs_run", FLUSH, 0, 0);
    idle();
    step("rs_idle", NORM, 0, 1);

    @(negedge clk);
    #1;
    checkVal("drain", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline. It is the counterpart to operand bypassing and handles every RAW hazard that bypassing cannot resolve.
- It inspects the instructions held in IF/ID, ID/EX and EX/MEM, then drives the PC and pipeline-register write enables and the flush controls.
- It sequences stalls of one or more cycles with a small FSM and a down-counter, and keeps stall/flush performance counters.
- It sits beside the ID stage. Branches and jumps resolve in ID.

Parameters:
- CNT_W, 32, width of the performance counters.
- MAX_STALL, 2, largest stall length the FSM sequences; sets the stall counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- IR_IF_ID_out  in  32  instruction in ID.
- IR_ID_EX_out  in  32  instruction in EX.
- RegWrite_ID_EX_out  in  1  EX instruction writes the register file.
- MemRead_ID_EX_out  in  1  EX instruction is a load.
- RegDst_ID_EX_out  in  2  EX destination select: 00 = rt, 01 = rd, other = $31.
- IR_EX_MEM_out  in  32  instruction in MEM.
- MemRead_EX_MEM_out  in  1  MEM instruction is a load.
- RegDst_EX_MEM_out  in  2  same encoding as above.
- Branch_ID  in  1  ID instruction is beq/bne (compares in ID).
- JumpReg_ID  in  1  ID instruction is jr/jalr (reads rs in ID).
- BranchTaken_ID  in  1  ID branch condition true.
- Jump_ID  in  1  ID instruction is j/jal/jr/jalr.
- DMem_Busy  in  1  data memory not ready; freeze the whole pipeline.
- PC_Write  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- IF_ID_Flush  out  1  zero IF/ID (bubble) next edge.
- ID_EX_Flush  out  1  insert bubble into ID/EX next edge.
- Pipe_Hold  out  1  hold ID/EX, EX/MEM, MEM/WB.
- Stall_Count  out  CNT_W  cycles with ID_EX_Flush=1.
- Flush_Count  out  CNT_W  cycles with IF_ID_Flush=1.

Behaviour:
Destination and source decoding:
- Destination address: rt (IR[20:16]) for 00, rd (IR[15:11]) for 01, 31 otherwise. A destination of 0 never matches.
- ID sources: rs = IR_IF_ID_out[25:21] is always read.
- rt = IR_IF_ID_out[20:16] is read only when opcode is 0x00 (R-type), 0x04, 0x05 or 0x2B.

Stall need, computed in RUN; need = maximum of the applicable terms:
- Load-use: EX is a load and its destination matches an ID source → 1.
- Branch or JumpReg in ID with EX RegWrite, non-load, matching rs/rt → 1.
- Branch or JumpReg in ID with EX load matching rs/rt → 2.
- Branch or JumpReg in ID with MEM load matching rs/rt → 1.

FSM states: RUN, STALL. Stall counter cnt is ceil(log2(MAX_STALL+1)) bits.
- RUN, need=0:
  - PC_Write=1, IF_ID_Write=1, ID_EX_Flush=0.
  - IF_ID_Flush = BranchTaken_ID & Branch_ID | Jump_ID.
- RUN, need≥1:
  - PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0. Stall has priority over flush.
  - If need≥2: go to STALL with cnt = need−1. Otherwise stay in RUN.
- STALL:
  - Same stall outputs as RUN with need≥1. Detection is ignored.
  - cnt decrements each cycle; when cnt==1, return to RUN next edge.
  - In RUN, detection re-evaluates afresh.

DMem_Busy=1, in any state:
- PC_Write=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Flush=0, Pipe_Hold=1.
- FSM state, cnt and both counters hold.
- Pipe_Hold=0 otherwise.

Counters:
- Stall_Count increments on cycles with ID_EX_Flush=1.
- Flush_Count increments on cycles with IF_ID_Flush=1.
- Both wrap modulo 2^CNT_W.

Reset:
- State RUN, cnt=0, both counters 0.
- During the reset cycle: PC_Write=1, IF_ID_Write=1, all flushes 0, Pipe_Hold=0.
- Reset asserted mid-STALL abandons the stall.
- Outputs are combinational from the current state and inputs; no added latency.

Decomposition:
- Shared package holds:
  - opcode constants (R-type 0x00, BEQ 0x04, BNE 0x05, SW 0x2B, LW 0x23);
  - RegDst encoding constants;
  - the FSM state enum.
- One natural sub-module: hazard_dest_decode (IR + RegDst → 5-bit write address). It is instantiated twice, for EX and MEM.

Test Plan:
1. lw $8,0($9) in EX, then add $10,$8,$11 in ID → one cycle PC_Write=0, ID_EX_Flush=1; next cycle normal; Stall_Count=1.
2. lw $8 in EX, then beq $8,$0 in ID → two stall cycles (RUN→STALL→RUN); Stall_Count=2; third cycle BranchTaken_ID=1 gives IF_ID_Flush=1, Flush_Count=1.
3. add $8 in EX, then bne $8,$9 in ID → exactly one stall. Repeat with destination $0 → no stall.
4. lw $8 in EX, then sw $8,4($2) in ID (reads rt) → stall. Same with addi $8,$8,1 (rt not a source, rs=$8) → stall via rs. With ori $3,$4,1 → none.
5. DMem_Busy=1 for 3 cycles during the STALL state → Pipe_Hold=1, cnt frozen. After release the remaining stall cycle completes; Stall_Count total = 2.
6. reset=1 asserted in STALL → next cycle RUN, counters 0, PC_Write=1.
